// File: rtl/puf_pkg.sv
// Shared types and constants for the PUF response sequencer.
// Holds the FSM state encoding, default sizes, and the bit-decision rule.
package puf_pkg;

  localparam int unsigned CHAL_W_DEF        = 8;
  localparam int unsigned RESP_BITS_DEF     = 16;
  localparam int unsigned CNT_W_DEF         = 22;
  localparam int unsigned SETTLE_CYCLES_DEF = 4;
  localparam int unsigned TIMEOUT_W_DEF     = 24;
  localparam int unsigned TIE_CNT_W         = 8;

  typedef enum logic [2:0] {
    IDLE,
    CLEAR,
    SETTLE,
    RUN,
    DECIDE,
    DONE
  } state_e;

  typedef struct packed {
    logic bit_val;
    logic tie;
  } decide_t;

  // A lone finisher wins outright; otherwise the larger count wins, and equal counts are a tie scored as 0.
  function automatic decide_t decide_bit(input logic fin_a,
                                         input logic fin_b,
                                         input logic a_gt_b,
                                         input logic a_eq_b);
    decide_t r;
    r.bit_val = 1'b0;
    r.tie     = 1'b0;
    if (fin_a && !fin_b) begin
      r.bit_val = 1'b1;
    end else if (fin_b && !fin_a) begin
      r.bit_val = 1'b0;
    end else if (a_eq_b) begin
      r.tie = 1'b1;
    end else begin
      r.bit_val = a_gt_b;
    end
    return r;
  endfunction

endpackage

// File: rtl/puf_response_controller_if.sv
// Bundle between the response sequencer (slave) and its environment:
// host request side plus the two ring-oscillator counters.
interface puf_response_controller_if
  import puf_pkg::*;
#(
  parameter int unsigned CHAL_W    = CHAL_W_DEF,
  parameter int unsigned RESP_BITS = RESP_BITS_DEF,
  parameter int unsigned CNT_W     = CNT_W_DEF
) ();

  logic                 start;
  logic [CHAL_W-1:0]    chal_base;
  logic                 finished_a;
  logic                 finished_b;
  logic [CNT_W-1:0]     count_a;
  logic [CNT_W-1:0]     count_b;
  logic [CHAL_W-1:0]    sel_a;
  logic [CHAL_W-1:0]    sel_b;
  logic                 cnt_clr;
  logic                 cnt_en;
  logic                 busy;
  logic                 resp_valid;
  logic [RESP_BITS-1:0] response;
  logic [TIE_CNT_W-1:0] tie_cnt;
  logic                 timeout;

  modport master (
    output start, chal_base, finished_a, finished_b, count_a, count_b,
    input  sel_a, sel_b, cnt_clr, cnt_en, busy, resp_valid, response, tie_cnt, timeout
  );

  modport slave (
    input  start, chal_base, finished_a, finished_b, count_a, count_b,
    output sel_a, sel_b, cnt_clr, cnt_en, busy, resp_valid, response, tie_cnt, timeout
  );

endinterface

// File: rtl/puf_watchdog.sv
// Loadable up-counter with clear/enable and an all-ones terminal-count flag.
// Preloading near all-ones lets the same counter time short delays.
module puf_watchdog #(
  parameter int unsigned TIMEOUT_W = 24
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 clr,
  input  logic                 load,
  input  logic [TIMEOUT_W-1:0] load_val,
  input  logic                 en,
  output logic                 tc
);

  logic [TIMEOUT_W-1:0] count_d, count_q;

  always_comb begin
    count_d = count_q;
    if (clr) begin
      count_d = '0;
    end else if (load) begin
      count_d = load_val;
    end else if (en) begin
      count_d = count_q + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign tc = &count_q;

endmodule

// File: rtl/puf_response_controller.sv
// Sequences RO-pair races: per bit it selects a pair, clears, settles, runs and
// judges the two counters, shifting each verdict into the response word.
module puf_response_controller
  import puf_pkg::*;
#(
  parameter int unsigned CHAL_W        = CHAL_W_DEF,
  parameter int unsigned RESP_BITS     = RESP_BITS_DEF,
  parameter int unsigned CNT_W         = CNT_W_DEF,
  parameter int unsigned SETTLE_CYCLES = SETTLE_CYCLES_DEF,
  parameter int unsigned TIMEOUT_W     = TIMEOUT_W_DEF
) (
  input  logic                       clk,
  input  logic                       reset,
  puf_response_controller_if.slave   bus
);

  localparam int unsigned IDX_W = (RESP_BITS > 1) ? $clog2(RESP_BITS) : 1;
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(RESP_BITS - 1);
  // SETTLE reuses the watchdog: preload so all-ones arrives after SETTLE_CYCLES cycles.
  localparam logic [TIMEOUT_W-1:0] SETTLE_LOAD =
    {TIMEOUT_W{1'b1}} - TIMEOUT_W'(SETTLE_CYCLES - 1);

  state_e               state_d, state_q;
  logic [CHAL_W-1:0]    base_d, base_q;
  logic [CHAL_W-1:0]    sel_a_d, sel_a_q;
  logic [CHAL_W-1:0]    sel_b_d, sel_b_q;
  logic [IDX_W-1:0]     idx_d, idx_q;
  logic                 cnt_clr_d, cnt_clr_q;
  logic                 cnt_en_d, cnt_en_q;
  logic                 busy_d, busy_q;
  logic                 resp_valid_d, resp_valid_q;
  logic [RESP_BITS-1:0] response_d, response_q;
  logic [TIE_CNT_W-1:0] tie_cnt_d, tie_cnt_q;
  logic                 timeout_d, timeout_q;
  logic                 fin_a_d, fin_a_q;
  logic                 fin_b_d, fin_b_q;
  logic                 wd_clr, wd_load, wd_en, wd_tc;
  decide_t              dec;

  puf_watchdog #(.TIMEOUT_W(TIMEOUT_W)) u_watchdog (
    .clk      (clk),
    .reset    (reset),
    .clr      (wd_clr),
    .load     (wd_load),
    .load_val (SETTLE_LOAD),
    .en       (wd_en),
    .tc       (wd_tc)
  );

  always_comb begin
    dec          = decide_bit(fin_a_q, fin_b_q,
                              bus.count_a > bus.count_b,
                              bus.count_a == bus.count_b);
    state_d      = state_q;
    base_d       = base_q;
    sel_a_d      = sel_a_q;
    sel_b_d      = sel_b_q;
    idx_d        = idx_q;
    response_d   = response_q;
    tie_cnt_d    = tie_cnt_q;
    timeout_d    = timeout_q;
    fin_a_d      = fin_a_q;
    fin_b_d      = fin_b_q;
    wd_clr       = 1'b0;
    wd_load      = 1'b0;
    wd_en        = 1'b0;

    case (state_q)
      IDLE: begin
        if (bus.start) begin
          base_d     = bus.chal_base;
          idx_d      = '0;
          response_d = '0;
          timeout_d  = 1'b0;
          state_d    = CLEAR;
        end
      end
      CLEAR: begin
        wd_load = 1'b1;
        state_d = SETTLE;
      end
      SETTLE: begin
        if (wd_tc) begin
          wd_clr  = 1'b1;
          state_d = RUN;
        end else begin
          wd_en = 1'b1;
        end
      end
      RUN: begin
        wd_en = 1'b1;
        if (bus.finished_a || bus.finished_b) begin
          fin_a_d = bus.finished_a;
          fin_b_d = bus.finished_b;
          state_d = DECIDE;
        end else if (wd_tc) begin
          fin_a_d   = 1'b0;
          fin_b_d   = 1'b0;
          timeout_d = 1'b1;
          state_d   = DECIDE;
        end
      end
      DECIDE: begin
        response_d = {response_q[RESP_BITS-2:0], dec.bit_val};
        if (dec.tie && (tie_cnt_q != {TIE_CNT_W{1'b1}})) begin
          tie_cnt_d = tie_cnt_q + 1'b1;
        end
        if (idx_q == IDX_LAST) begin
          state_d = DONE;
        end else begin
          idx_d   = idx_q + 1'b1;
          state_d = CLEAR;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    // Selects are computed on entry to CLEAR so they are stable for the whole clear/settle window.
    if (state_d == CLEAR) begin
      sel_a_d = base_d + CHAL_W'({idx_d, 1'b0});
      sel_b_d = sel_a_d + 1'b1;
    end

    cnt_clr_d    = (state_d == IDLE) || (state_d == CLEAR) || (state_d == DONE);
    cnt_en_d     = (state_d == RUN);
    busy_d       = (state_d != IDLE);
    resp_valid_d = (state_d == DONE);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= IDLE;
      base_q       <= '0;
      sel_a_q      <= '0;
      sel_b_q      <= '0;
      idx_q        <= '0;
      cnt_clr_q    <= 1'b1;
      cnt_en_q     <= 1'b0;
      busy_q       <= 1'b0;
      resp_valid_q <= 1'b0;
      response_q   <= '0;
      tie_cnt_q    <= '0;
      timeout_q    <= 1'b0;
      fin_a_q      <= 1'b0;
      fin_b_q      <= 1'b0;
    end else begin
      state_q      <= state_d;
      base_q       <= base_d;
      sel_a_q      <= sel_a_d;
      sel_b_q      <= sel_b_d;
      idx_q        <= idx_d;
      cnt_clr_q    <= cnt_clr_d;
      cnt_en_q     <= cnt_en_d;
      busy_q       <= busy_d;
      resp_valid_q <= resp_valid_d;
      response_q   <= response_d;
      tie_cnt_q    <= tie_cnt_d;
      timeout_q    <= timeout_d;
      fin_a_q      <= fin_a_d;
      fin_b_q      <= fin_b_d;
    end
  end

  assign bus.sel_a      = sel_a_q;
  assign bus.sel_b      = sel_b_q;
  assign bus.cnt_clr    = cnt_clr_q;
  assign bus.cnt_en     = cnt_en_q;
  assign bus.busy       = busy_q;
  assign bus.resp_valid = resp_valid_q;
  assign bus.response   = response_q;
  assign bus.tie_cnt    = tie_cnt_q;
  assign bus.timeout    = timeout_q;

endmodule

// File: doc/puf_response_controller.md
Name: puf_response_controller

Overview:
Sequencer directly downstream of a pair of post-mux ring-oscillator counters (A and B). For each response bit it selects an RO pair via the mux selects, clears and runs both counters, decides which counter saturates first, and shifts that bit into a response word. It emits a RESP_BITS-wide PUF response per start request.

Parameters:
CHAL_W, 8, width of each RO mux select
RESP_BITS, 16, response bits generated per start
CNT_W, 22, counter width (finish = MSB of count set)
SETTLE_CYCLES, 4, idle cycles after clear before enabling counters (mux settle)
TIMEOUT_W, 24, width of run-phase watchdog; timeout at all-ones

Ports:
clk  in  1  system clock
reset  in  1  asynchronous, active-high reset
start  in  1  request a response; sampled only in IDLE
chal_base  in  CHAL_W  base challenge; latched on accepted start
finished_a  in  1  counter A finished flag
finished_b  in  1  counter B finished flag
count_a  in  CNT_W  counter A value
count_b  in  CNT_W  counter B value
sel_a  out  CHAL_W  RO mux select for counter A
sel_b  out  CHAL_W  RO mux select for counter B
cnt_clr  out  1  registered clear to both counters (drives their reset)
cnt_en  out  1  registered enable to both counters
busy  out  1  high in every state except IDLE
resp_valid  out  1  one-cycle pulse, response final
response  out  RESP_BITS  response word; held until next accepted start
tie_cnt  out  8  saturating count of unresolved ties since reset
timeout  out  1  sticky; set if any bit in current run hit watchdog

Behaviour:
- Reset: state IDLE; sel_a=sel_b=0, cnt_clr=1, cnt_en=0, busy=0, resp_valid=0, response=0, tie_cnt=0, timeout=0, idx=0.
- All outputs registered; cnt_clr/cnt_en glitch-free.
- IDLE: cnt_clr=1, cnt_en=0. start=1 -> latch chal_base, idx=0, response=0, timeout=0 -> CLEAR. start while busy ignored.
- CLEAR (1 cycle): sel_a=(base+2*idx) mod 2^CHAL_W, sel_b=sel_a+1 mod 2^CHAL_W; cnt_clr=1 -> SETTLE.
- SETTLE: cnt_clr=0, cnt_en=0 for SETTLE_CYCLES cycles -> RUN.
- RUN: cnt_en=1, watchdog counts from 0. Exit to DECIDE when finished_a|finished_b, or watchdog all-ones (set timeout).
- DECIDE (1 cycle, cnt_en=0): bit = 1 if finished_a & !finished_b; 0 if finished_b & !finished_a; if both or neither (timeout): bit = (count_a > count_b); if count_a==count_b, bit=0 and tie_cnt++ (saturates at 255). response <= {response[RESP_BITS-2:0], bit} (first bit ends in MSB). If idx==RESP_BITS-1 -> DONE, else idx++ -> CLEAR.
- DONE (1 cycle): resp_valid=1, cnt_clr=1 -> IDLE. Earliest next start accepted the cycle after DONE.
- Latency per bit: 1 + SETTLE_CYCLES + run + 1 cycles; run >= 1.
- finished inputs sampled only in RUN; stale flags in other states ignored.
- Reset mid-operation: immediate return to reset values, partial response discarded, no resp_valid.

Decomposition:
- Package puf_pkg: state enum (IDLE, CLEAR, SETTLE, RUN, DECIDE, DONE), default parameter constants, decide-bit function.
- One sub-module: puf_watchdog (loadable TIMEOUT_W up-counter with clear/enable and terminal-count flag), reused for SETTLE and RUN timing.

Test Plan:
- Reset release, no start -> busy=0, cnt_clr=1, response=0 indefinitely.
- start, chal_base=8'h10, RESP_BITS=16, A always finishes first -> response=16'hFFFF, resp_valid one pulse; sel_a visits 10,12,...,2E.
- Alternating winner B,A,B,A... -> response=16'h5555; cnt_en never high in CLEAR/SETTLE.
- chal_base=8'hFE -> sel_a=FE, sel_b=FF; next bit sel_a=00, sel_b=01 (wrap).
- Both finished same cycle with count_a==count_b -> bit 0, tie_cnt increments by 1; no finish ever (TIMEOUT_W=8) -> timeout=1 after 255 RUN cycles, bit from count compare.
- reset asserted during RUN at idx=5 -> outputs to reset values next edge, no resp_valid; fresh start yields full 16-bit response.
